// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the memory port arbiter:
//   - MEM_ADDR_SIZE / WORD_SIZE_BIT: system address and data word widths.
//   - arb_state_e: arbiter FSM state encoding.
package mem_port_arbiter_pkg;

  localparam int MEM_ADDR_SIZE = 32;
  localparam int WORD_SIZE_BIT = 32;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_RD_ISSUE = 3'd1,
    ARB_RD_WAIT  = 3'd2,
    ARB_WR_ISSUE = 3'd3,
    ARB_WR_WAIT  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-ported data memory between cache read-miss fills and
//   write-buffer drains. One memory transaction at a time; completion goes
//   back to the requester that owns it. A read never passes a pending
//   buffered write to the same address.
//
//   Optional feature: define MEM_ARB_AGING_EN to add write aging. A saturating
//   counter of read grants taken while a write waits forces a write once it
//   reaches STARVE_LIMIT. Without it, reads always win unless the write buffer
//   is full or the addresses conflict.
//
// Ports
//   clock, reset                  clock, async active-low reset
//   rd_req/rd_addr                read-miss request (held until rd_done)
//   rd_gnt/rd_done/rd_data        read accepted pulse, completion pulse, data
//   wr_req/wr_addr/wr_data        write-buffer head (held until wr_done)
//   wr_full                       write buffer full
//   wr_gnt/wr_done                write accepted pulse, completion pulse (pop)
//   mem_read/mem_write            1-cycle memory start pulses
//   mem_addr/mem_wdata            held from issue through mem_done
//   mem_rdata/mem_done            memory completion and read data
//
// state        | meaning
// -------------+------------------------------------------------------
// ARB_IDLE     | choose the next transaction (one cycle between each)
// ARB_RD_ISSUE | rd_gnt + mem_read pulse
// ARB_RD_WAIT  | wait for mem_done, then pulse rd_done
// ARB_WR_ISSUE | wr_gnt + mem_write pulse
// ARB_WR_WAIT  | wait for mem_done, then pulse wr_done
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = MEM_ADDR_SIZE,
  parameter int DATA_W       = WORD_SIZE_BIT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_full,
  output logic              wr_gnt,
  output logic              wr_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done
);

  arb_state_e state, next_state;
  logic       aging_force;

  // Grants and memory strobes come straight from state so an async reset
  // clears them in the same instant.
  assign rd_gnt    = (state == ARB_RD_ISSUE);
  assign mem_read  = (state == ARB_RD_ISSUE);
  assign wr_gnt    = (state == ARB_WR_ISSUE);
  assign mem_write = (state == ARB_WR_ISSUE);

`ifdef MEM_ARB_AGING_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (wr_gnt) begin
      starve_cnt <= '0;
    end else if (rd_gnt && wr_req && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign aging_force = wr_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
  assign aging_force = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Selection priority in IDLE: full buffer, RAW conflict, aging, read, write.
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: begin
        if (wr_req && wr_full)                         next_state = ARB_WR_ISSUE;
        else if (rd_req && wr_req && rd_addr == wr_addr) next_state = ARB_WR_ISSUE;
        else if (aging_force)                          next_state = ARB_WR_ISSUE;
        else if (rd_req)                               next_state = ARB_RD_ISSUE;
        else if (wr_req)                               next_state = ARB_WR_ISSUE;
      end
      ARB_RD_ISSUE: next_state = ARB_RD_WAIT;
      ARB_WR_ISSUE: next_state = ARB_WR_WAIT;
      ARB_RD_WAIT:  if (mem_done) next_state = ARB_IDLE;
      ARB_WR_WAIT:  if (mem_done) next_state = ARB_IDLE;
      default:      next_state = ARB_IDLE;
    endcase
  end

  // Address/data are captured on the IDLE decision edge so they are already
  // valid in the ISSUE cycle alongside the strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == ARB_IDLE && next_state == ARB_RD_ISSUE) begin
      mem_addr  <= rd_addr;
    end else if (state == ARB_IDLE && next_state == ARB_WR_ISSUE) begin
      mem_addr  <= wr_addr;
      mem_wdata <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_done <= 1'b0;
      wr_done <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_done <= (state == ARB_RD_WAIT) && mem_done;
      wr_done <= (state == ARB_WR_WAIT) && mem_done;
      if ((state == ARB_RD_WAIT) && mem_done) begin
        rd_data <= mem_rdata;
      end
    end
  end

  starve_limit_valid: assert property (@(posedge clock) STARVE_LIMIT > 0);

  rd_req_held: assert property (@(posedge clock) disable iff (!reset)
    (state inside {ARB_RD_ISSUE, ARB_RD_WAIT}) |-> rd_req);

  wr_req_held: assert property (@(posedge clock) disable iff (!reset)
    (state inside {ARB_WR_ISSUE, ARB_WR_WAIT}) |-> wr_req);

  mem_done_in_wait: assert property (@(posedge clock) disable iff (!reset)
    mem_done |-> (state inside {ARB_RD_WAIT, ARB_WR_WAIT}));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a memory responder model whose
//   completion latency is set per test. Builds with or without
//   MEM_ARB_AGING_EN; the starvation test picks its expected grant pattern
//   accordingly.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic [31:0] rd_data;
  logic        rd_done;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_full;
  logic        wr_gnt;
  logic        wr_done;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;

  int vectors = 0;
  int miscompares = 0;
  int lat = 3;
  logic [31:0] mem_model [logic [31:0]];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full),
    .wr_gnt(wr_gnt), .wr_done(wr_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  always #5 clock = ~clock;

  // Memory responder: captures the transaction at the strobe, completes it
  // 'lat' cycles later, and abandons it if reset is seen while waiting.
  initial begin
    mem_done  = 1'b0;
    mem_rdata = '0;
    forever begin
      logic [31:0] a;
      logic [31:0] d;
      logic        is_wr;
      logic        abort;
      @(posedge clock); #1;
      if (reset === 1'b1 && (mem_read || mem_write)) begin
        a = mem_addr; d = mem_wdata; is_wr = mem_write; abort = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(posedge clock); #1;
          if (reset !== 1'b1) abort = 1'b1;
        end
        if (!abort) begin
          if (is_wr) mem_model[a] = d;
          else mem_rdata = mem_model.exists(a) ? mem_model[a] : 32'h0;
          mem_done = 1'b1;
          @(posedge clock); #1;
          mem_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0: return rd_gnt === 1'b1;
      1: return wr_gnt === 1'b1;
      2: return rd_done === 1'b1;
      3: return wr_done === 1'b1;
      4: return (rd_gnt === 1'b1) || (wr_gnt === 1'b1);
      default: return (rd_done === 1'b1) || (wr_done === 1'b1);
    endcase
  endfunction

  // Advances until the selected signal is high; n = cycles taken, 0 on timeout.
  task automatic wait_sig(input int sel, input int limit, input string tag, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (sig(sel)) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: no event within %0d cycles", tag, limit);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_gnt"},    rd_gnt,    0);
    check({tag, "_wr_gnt"},    wr_gnt,    0);
    check({tag, "_mem_read"},  mem_read,  0);
    check({tag, "_mem_write"}, mem_write, 0);
    check({tag, "_rd_done"},   rd_done,   0);
    check({tag, "_wr_done"},   wr_done,   0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_rd_data"},   rd_data,   0);
  endtask

  initial begin
    int n;
    int dones;
    bit exp_wr;
    reset = 1'b0; rd_req = 0; rd_addr = 0; wr_req = 0; wr_addr = 0; wr_data = 0; wr_full = 0;
    mem_model[32'h40] = 32'hDEAD;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Test 1: read only; gnt in the cycle after the IDLE decide cycle,
    // mem_done 3 cycles after mem_read, rd_done one cycle after mem_done.
    lat = 3;
    rd_req = 1; rd_addr = 32'h40;
    tick();
    check("t1_rd_gnt", rd_gnt, 1);
    check("t1_mem_read", mem_read, 1);
    check("t1_mem_addr", mem_addr, 32'h40);
    check("t1_wr_gnt", wr_gnt, 0);
    wait_sig(2, 20, "t1_rd_done", n);
    check("t1_done_lat", n, 4);
    check("t1_rd_data", rd_data, 32'hDEAD);
    rd_req = 0;
    tick();
    check("t1_done_pulse", rd_done, 0);

    // Test 2: read 0x10 and write 0x20 together; read first, write right after.
    rd_req = 1; rd_addr = 32'h10; wr_req = 1; wr_addr = 32'h20; wr_data = 32'hA5A5;
    tick();
    check("t2_rd_gnt", rd_gnt, 1);
    check("t2_wr_gnt", wr_gnt, 0);
    check("t2_mem_addr", mem_addr, 32'h10);
    wait_sig(2, 20, "t2_rd_done", n);
    rd_req = 0;
    tick();
    check("t2_wr_gnt_after", wr_gnt, 1);
    check("t2_mem_write", mem_write, 1);
    check("t2_wr_addr", mem_addr, 32'h20);
    check("t2_wr_wdata", mem_wdata, 32'hA5A5);
    wait_sig(3, 20, "t2_wr_done", n);
    check("t2_wr_lat", n, 4);
    wr_req = 0;
    check("t2_mem_written", mem_model.exists(32'h20) ? mem_model[32'h20] : 32'h0, 32'hA5A5);

    // Test 3: RAW conflict on 0x30; write goes first, read returns written data.
    tick();
    rd_req = 1; rd_addr = 32'h30; wr_req = 1; wr_addr = 32'h30; wr_data = 32'h55;
    tick();
    check("t3_wr_gnt", wr_gnt, 1);
    check("t3_rd_gnt", rd_gnt, 0);
    check("t3_mem_addr", mem_addr, 32'h30);
    wait_sig(3, 20, "t3_wr_done", n);
    wr_req = 0;
    tick();
    check("t3_rd_gnt_after", rd_gnt, 1);
    wait_sig(2, 20, "t3_rd_done", n);
    check("t3_rd_data", rd_data, 32'h55);
    rd_req = 0;

    // Test 4: full write buffer beats a pending read at a different address.
    tick();
    rd_req = 1; rd_addr = 32'h44; wr_req = 1; wr_addr = 32'h80; wr_data = 32'h1234; wr_full = 1;
    tick();
    check("t4_wr_gnt", wr_gnt, 1);
    check("t4_rd_gnt", rd_gnt, 0);
    wait_sig(3, 20, "t4_wr_done", n);
    wr_req = 0; wr_full = 0;
    tick();
    check("t4_rd_gnt_after", rd_gnt, 1);
    wait_sig(2, 20, "t4_rd_done", n);
    rd_req = 0;

    // Test 5: continuous read and write requests, no conflict.
    // With aging: 4 reads then 1 write, repeating. Without: reads only.
    tick();
    lat = 1;
    rd_req = 1; rd_addr = 32'h100; wr_req = 1; wr_addr = 32'h200; wr_data = 32'h77;
    for (int g = 0; g < 10; g++) begin
`ifdef MEM_ARB_AGING_EN
      exp_wr = (g % 5) == 4;
`else
      exp_wr = 1'b0;
`endif
      wait_sig(4, 20, "t5_grant", n);
      check($sformatf("t5_grant%0d_is_wr", g), wr_gnt, exp_wr);
    end
    wait_sig(5, 20, "t5_last_done", n);
    rd_req = 0;
    tick();
    check("t5_wr_after_rd_drop", wr_gnt, 1);
    wait_sig(3, 20, "t5_wr_done", n);
    wr_req = 0;

    // Test 6: reset during RD_WAIT drops the transaction silently.
    tick();
    lat = 8;
    rd_req = 1; rd_addr = 32'h40;
    tick();
    check("t6_rd_gnt", rd_gnt, 1);
    tick(); tick();
    reset = 1'b0;
    #1;
    check_all_zero("t6_reset");
    rd_req = 0;
    tick(); tick();
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_done === 1'b1) dones++;
    end
    check("t6_no_rd_done", dones, 0);
    lat = 2;
    rd_req = 1; rd_addr = 32'h30;
    tick();
    check("t6_new_rd_gnt", rd_gnt, 1);
    wait_sig(2, 20, "t6_new_rd_done", n);
    check("t6_new_lat", n, 3);
    check("t6_new_rd_data", rd_data, 32'h55);
    rd_req = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
